wb_cmd_master: RTL and testbench

- Wishbone initiator that turns a byte-oriented command stream (from the host link receiver) into single 8-bit-data / 16-bit-address Wishbone read or write cycles.
- Returns a status/data byte response stream.
- Sits upstream of the bus dispatch logic and drives its requester port.
- Bounds every cycle with a timeout so an unmapped or hung responder cannot stall the host link.

---
 rtl/wb_cmd_master_pkg.sv | 21 ++
 rtl/wb_cmd_master.sv | 146 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared constants and state encoding for the byte-command Wishbone initiator.
package wb_cmd_master_pkg;

  localparam logic [7:0] OP_READ    = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BADOP   = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_BUS,
    S_RESP_STATUS,
    S_RESP_DATA
  } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Byte-stream command decoder driving single Wishbone read/write cycles with a
// bounded ack wait, answering with a status byte (plus data byte for reads).
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    status_reg, status_next;
  logic [7:0]    rd_data_reg, rd_data_next;
  logic          we_reg, we_next;
  logic [15:0]   adr_reg, adr_next;
  logic [7:0]    dat_reg, dat_next;
  logic          rx_ready_reg, rx_ready_next;
  logic          tx_valid_reg, tx_valid_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          stb_reg, stb_next;

  logic rx_fire, tx_fire;
  assign rx_fire = rx_valid & rx_ready_reg;
  assign tx_fire = tx_valid_reg & tx_ready;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    status_next  = status_reg;
    rd_data_next = rd_data_reg;
    we_next      = we_reg;
    adr_next     = adr_reg;
    dat_next     = dat_reg;

    case (state_reg)
      S_IDLE: if (rx_fire) begin
        if (rx_data == OP_READ || rx_data == OP_WRITE) begin
          we_next    = (rx_data == OP_WRITE);
          state_next = S_ADDR_HI;
        end else begin
          status_next = ST_BADOP;
          state_next  = S_RESP_STATUS;
        end
      end
      S_ADDR_HI: if (rx_fire) begin
        adr_next[15:8] = rx_data;
        state_next     = S_ADDR_LO;
      end
      S_ADDR_LO: if (rx_fire) begin
        adr_next[7:0] = rx_data;
        cnt_next      = '0;
        state_next    = we_reg ? S_DATA : S_BUS;
      end
      S_DATA: if (rx_fire) begin
        dat_next   = rx_data;
        cnt_next   = '0;
        state_next = S_BUS;
      end
      S_BUS: begin
        cnt_next = cnt_reg + CW'(1);
        // Ack beats timeout when both land in the final wait cycle.
        if (wb_ack_i) begin
          if (!we_reg) rd_data_next = wb_dat_i;
          status_next = ST_OK;
          state_next  = S_RESP_STATUS;
        end else if (cnt_reg == CNT_LAST) begin
          rd_data_next = 8'h00;
          status_next  = ST_TIMEOUT;
          state_next   = S_RESP_STATUS;
        end
      end
      S_RESP_STATUS: if (tx_fire) begin
        state_next = (!we_reg && status_reg != ST_BADOP) ? S_RESP_DATA : S_IDLE;
      end
      S_RESP_DATA: if (tx_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    rx_ready_next = (state_next == S_IDLE) || (state_next == S_ADDR_HI) ||
                    (state_next == S_ADDR_LO) || (state_next == S_DATA);
    stb_next      = (state_next == S_BUS);
    tx_valid_next = (state_next == S_RESP_STATUS) || (state_next == S_RESP_DATA);
    tx_data_next  = tx_data_reg;
    if (state_next == S_RESP_STATUS)    tx_data_next = status_next;
    else if (state_next == S_RESP_DATA) tx_data_next = rd_data_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      status_reg   <= 8'h00;
      rd_data_reg  <= 8'h00;
      we_reg       <= 1'b0;
      adr_reg      <= 16'h0000;
      dat_reg      <= 8'h00;
      rx_ready_reg <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      stb_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      status_reg   <= status_next;
      rd_data_reg  <= rd_data_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      rx_ready_reg <= rx_ready_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      stb_reg      <= stb_next;
    end
  end

  assign rx_ready = rx_ready_reg;
  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign wb_stb_o = stb_reg;
  assign wb_cyc_o = stb_reg;
  assign wb_we_o  = we_reg;
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: write, read, timeout, bad opcode,
// response backpressure, async reset mid-cycle and ack/timeout race.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        wb_stb_o, wb_cyc_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i = 8'h00;
  logic        wb_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one byte at a negedge and returns at the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_%02h: rx_ready=%b expected 1", b, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, tx_data, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: rx_ready=%b tx_valid=%b tx_data=%h stb=%b cyc=%b we=%b adr=%h dat=%h expected all 0",
               rx_ready, tx_valid, tx_data, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: rx_ready=%b expected 1", rx_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_write();
    int stb_cycles = 0;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h23); send_byte(8'h5A);
    checks++;
    if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_adr_o !== 16'h0123 ||
        wb_we_o !== 1'b1 || wb_dat_o !== 8'h5A || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_bus: stb=%b cyc=%b adr=%h we=%b dat=%h rx_ready=%b expected 1 1 0123 1 5a 0",
               wb_stb_o, wb_cyc_o, wb_adr_o, wb_we_o, wb_dat_o, rx_ready);
    end
    for (int i = 0; i < 3; i++) begin
      if (wb_stb_o === 1'b1) stb_cycles++;
      if (i == 2) wb_ack_i = 1'b1;
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    checks++;
    if (stb_cycles != 3 || wb_stb_o !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL write_resp: stb_cycles=%0d stb=%b tx_valid=%b tx_data=%h expected 3 0 1 00",
               stb_cycles, wb_stb_o, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_done: tx_valid=%b rx_ready=%b expected 0 1", tx_valid, rx_ready);
    end
    $display("write 02 01 23 5a: status=%h", 8'h00);
  endtask

  task automatic test_read();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    checks++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 16'h0004 || wb_we_o !== 1'b0) begin
      errors++;
      $display("FAIL read_bus: stb=%b adr=%h we=%b expected 1 0004 0", wb_stb_o, wb_adr_o, wb_we_o);
    end
    wb_dat_i = 8'h3C;
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    checks++;
    if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL read_status: stb=%b cyc=%b tx_valid=%b tx_data=%h expected 0 0 1 00",
               wb_stb_o, wb_cyc_o, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL read_data: tx_valid=%b tx_data=%h expected 1 3c", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done: tx_valid=%b rx_ready=%b expected 0 1", tx_valid, rx_ready);
    end
    $display("read 01 00 04: resp 00 3c");
  endtask

  task automatic test_timeout();
    int stb_cycles = 0;
    send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    while (wb_stb_o === 1'b1 && stb_cycles < 50) begin
      stb_cycles++;
      @(negedge clk);
    end
    checks++;
    if (stb_cycles != 8) begin
      errors++;
      $display("FAIL timeout_len: stb_cycles=%0d expected 8", stb_cycles);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL timeout_status: tx_valid=%b tx_data=%h expected 1 01", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL timeout_data: tx_valid=%b tx_data=%h expected 1 00", tx_valid, tx_data);
    end
    wb_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    wb_ack_i = 1'b0;
    checks++;
    if (wb_stb_o !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_ack: stb=%b tx_valid=%b rx_ready=%b expected 0 0 1", wb_stb_o, tx_valid, rx_ready);
    end
    $display("read 01 ab cd (no ack): resp 01 00");
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h7F);
    checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h02 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL badop_status: rx_ready=%b tx_valid=%b tx_data=%h stb=%b expected 0 1 02 0",
               rx_ready, tx_valid, tx_data, wb_stb_o);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL badop_single: tx_valid=%b stb=%b expected 0 0", tx_valid, wb_stb_o);
    end
    $display("bad opcode 7f: resp 02");
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10); send_byte(8'hAA);
    checks++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 16'h0010 || wb_dat_o !== 8'hAA || wb_we_o !== 1'b1) begin
      errors++;
      $display("FAIL badop_write_bus: stb=%b adr=%h dat=%h we=%b expected 1 0010 aa 1",
               wb_stb_o, wb_adr_o, wb_dat_o, wb_we_o);
    end
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL badop_write_resp: tx_valid=%b tx_data=%h expected 1 00", tx_valid, tx_data);
    end
    @(negedge clk);
    $display("write 02 00 10 aa: resp 00");
  endtask

  task automatic test_backpressure();
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    tx_ready = 1'b0;
    wb_dat_i = 8'h99;
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h00 || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: tx_valid=%b tx_data=%h rx_ready=%b expected 1 00 0",
                 i, tx_valid, tx_data, rx_ready);
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h99 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_data: tx_valid=%b tx_data=%h rx_ready=%b expected 1 99 0",
               tx_valid, tx_data, rx_ready);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_done: tx_valid=%b rx_ready=%b expected 0 1", tx_valid, rx_ready);
    end
    $display("read 01 12 34 (tx stalled 5): resp 00 99");
  endtask

  task automatic test_reset_mid_bus();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (wb_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_bus: stb=%b expected 1", wb_stb_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0 || wb_adr_o !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async: stb=%b cyc=%b rx_ready=%b tx_valid=%b adr=%h expected 0 0 0 0 0000",
               wb_stb_o, wb_cyc_o, rx_ready, tx_valid, wb_adr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: rx_ready=%b tx_valid=%b stb=%b expected 1 0 0", rx_ready, tx_valid, wb_stb_o);
    end
    $display("reset mid-bus: outputs cleared");
  endtask

  task automatic test_ack_timeout_race();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++;
    if (wb_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL race_stb_cycle8: stb=%b expected 1", wb_stb_o);
    end
    wb_dat_i = 8'h5E;
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    checks++;
    if (wb_stb_o !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL race_status: stb=%b tx_valid=%b tx_data=%h expected 0 1 00", wb_stb_o, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h5E) begin
      errors++;
      $display("FAIL race_data: tx_valid=%b tx_data=%h expected 1 5e", tx_valid, tx_data);
    end
    @(negedge clk);
    $display("read 01 00 20 (ack on last cycle): resp 00 5e");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_bad_opcode();
    test_backpressure();
    test_reset_mid_bus();
    test_ack_timeout_race();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
